fifo_wr_sched: RTL and testbench



---
 rtl/fifo_wr_sched.sv | 117 +++++++++++
 tb/tb_fifo_wr_sched.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_sched.sv
// Write-side scheduler for the width-transform FIFO: packs narrow beats per requester
// into FIFO-width words and issues them round-robin to the FIFO write port.
module fifo_wr_sched #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned DW    = 8,
  parameter int unsigned RATIO = 4,
  parameter int unsigned SRCW  = 1,
  parameter int unsigned CNTW  = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic [NREQ-1:0]      in_valid,
  output logic [NREQ-1:0]      in_ready,
  input  logic [NREQ-1:0]      in_last,
  input  logic [NREQ*DW-1:0]   in_data,
  input  logic                 full,
  output logic                 wr_req,
  output logic [DW*RATIO-1:0]  wr_data,
  output logic [SRCW-1:0]      wr_src,
  output logic [CNTW-1:0]      wr_nbeats
);

  localparam int unsigned WW = DW * RATIO;

  logic [WW-1:0]   pack_q   [NREQ];
  logic [WW-1:0]   pack_d   [NREQ];
  logic [CNTW-1:0] cnt_q    [NREQ];
  logic [CNTW-1:0] cnt_d    [NREQ];
  logic [CNTW-1:0] nbeats_q [NREQ];
  logic [CNTW-1:0] nbeats_d [NREQ];
  logic [NREQ-1:0] pending_q, pending_d;
  logic [SRCW-1:0] ptr_q, ptr_d;
  logic [SRCW-1:0] win;
  logic            any_pend;

  assign in_ready = {NREQ{rstn}} & ~pending_q;

  // Round-robin pick: unrolled per pointer value, scanned backwards so the nearest candidate wins.
  always_comb begin
    win      = '0;
    any_pend = |pending_q;
    for (int unsigned p = 0; p < NREQ; p++) begin
      if (ptr_q == SRCW'(p)) begin
        for (int unsigned k = NREQ; k > 0; k--) begin
          if (pending_q[(p + k - 1) % NREQ]) win = SRCW'((p + k - 1) % NREQ);
        end
      end
    end
  end

  // Write port, zeroed when idle.
  always_comb begin
    wr_req    = en & ~full & any_pend;
    wr_data   = '0;
    wr_src    = '0;
    wr_nbeats = '0;
    if (wr_req) begin
      wr_src = win;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (win == SRCW'(i)) begin
          wr_data   = pack_q[i];
          wr_nbeats = nbeats_q[i];
        end
      end
    end
  end

  always_comb begin
    pack_d    = pack_q;
    cnt_d     = cnt_q;
    nbeats_d  = nbeats_q;
    pending_d = pending_q;
    ptr_d     = ptr_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        // Clearing at lane 0 leaves unwritten upper lanes zero on a short word.
        if (cnt_q[i] == '0) pack_d[i] = '0;
        for (int unsigned l = 0; l < RATIO; l++) begin
          if (cnt_q[i] == CNTW'(l)) pack_d[i][l*DW +: DW] = in_data[i*DW +: DW];
        end
        if (in_last[i] || (cnt_q[i] == CNTW'(RATIO - 1))) begin
          pending_d[i] = 1'b1;
          nbeats_d[i]  = cnt_q[i] + CNTW'(1);
          cnt_d[i]     = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNTW'(1);
        end
      end
    end
    if (wr_req) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (win == SRCW'(i)) pending_d[i] = 1'b0;
      end
      ptr_d = (win == SRCW'(NREQ - 1)) ? '0 : win + SRCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        pack_q[i]   <= '0;
        cnt_q[i]    <= '0;
        nbeats_q[i] <= '0;
      end
      pending_q <= '0;
      ptr_q     <= '0;
    end else begin
      pack_q    <= pack_d;
      cnt_q     <= cnt_d;
      nbeats_q  <= nbeats_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Directed self-checking bench for fifo_wr_sched (NREQ=2, DW=8, RATIO=4).
module tb_fifo_wr_sched;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned DW    = 8;
  localparam int unsigned RATIO = 4;
  localparam int unsigned SRCW  = 1;
  localparam int unsigned CNTW  = 3;

  logic                clk = 1'b0;
  logic                rstn;
  logic                en;
  logic                full;
  logic [NREQ-1:0]     in_valid;
  logic [NREQ-1:0]     in_ready;
  logic [NREQ-1:0]     in_last;
  logic [NREQ*DW-1:0]  in_data;
  logic                wr_req;
  logic [DW*RATIO-1:0] wr_data;
  logic [SRCW-1:0]     wr_src;
  logic [CNTW-1:0]     wr_nbeats;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fifo_wr_sched #(
    .NREQ(NREQ), .DW(DW), .RATIO(RATIO), .SRCW(SRCW), .CNTW(CNTW)
  ) u_dut (
    .clk(clk), .rstn(rstn), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_data(in_data),
    .full(full),
    .wr_req(wr_req), .wr_data(wr_data), .wr_src(wr_src), .wr_nbeats(wr_nbeats)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic req, input logic [31:0] data,
                          input logic [31:0] src, input logic [31:0] nb);
    check_eq({tag, ".req"},  32'(wr_req),    32'(req));
    check_eq({tag, ".data"}, wr_data,        data);
    check_eq({tag, ".src"},  32'(wr_src),    src);
    check_eq({tag, ".nb"},   32'(wr_nbeats), nb);
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] l,
                       input logic [7:0] d0, input logic [7:0] d1);
    in_valid = v;
    in_last  = l;
    in_data  = {d1, d0};
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; full = 1'b0;
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    smp;
    check_eq("rst.ready", 32'(in_ready), 32'h0);
    cyc; cyc;
    rstn = 1'b1;
    smp;
    check_eq("rst.ready_up", 32'(in_ready), 32'h3);
    check_wr("rst", 1'b0, 32'h0, 32'h0, 32'h0);
    cyc;

    // Full word on requester 0.
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, 2'b00, 8'(8'h11 * (k + 1)), 8'h00);
      smp;
      check_eq("t1.idle", 32'(wr_req), 32'h0);
      cyc;
    end
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    smp;
    check_wr("t1", 1'b1, 32'h44332211, 32'h0, 32'h4);
    check_eq("t1.ready_lo", 32'(in_ready), 32'h2);
    cyc;
    smp;
    check_eq("t1.ready_hi", 32'(in_ready), 32'h3);
    check_eq("t1.after", 32'(wr_req), 32'h0);
    cyc;

    // Short word on requester 1, then a 1-beat word starting back at lane 0.
    drive(2'b10, 2'b00, 8'h00, 8'hAA); smp; cyc;
    drive(2'b10, 2'b10, 8'h00, 8'hBB); smp; cyc;
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    smp;
    check_wr("t2", 1'b1, 32'h0000BBAA, 32'h1, 32'h2);
    check_eq("t2.ready", 32'(in_ready), 32'h1);
    cyc;
    drive(2'b10, 2'b10, 8'h00, 8'hCC);
    smp;
    check_eq("t2.ready_back", 32'(in_ready), 32'h3);
    cyc;
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    smp;
    check_wr("t2b", 1'b1, 32'h000000CC, 32'h1, 32'h1);
    cyc;

    // Simultaneous completion with ptr=0.
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 2'b00, 8'(16 * (k + 1)), 8'(8'h50 + 16 * k));
      smp; cyc;
    end
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    smp; check_wr("t3a", 1'b1, 32'h40302010, 32'h0, 32'h4); cyc;
    smp; check_wr("t3b", 1'b1, 32'h80706050, 32'h1, 32'h4); cyc;
    smp; check_wr("t3idle", 1'b0, 32'h0, 32'h0, 32'h0); cyc;

    // Move ptr to 1, then simultaneous completion again.
    drive(2'b01, 2'b01, 8'hE0, 8'h00); smp; cyc;
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    smp; check_wr("t3c", 1'b1, 32'h000000E0, 32'h0, 32'h1); cyc;
    drive(2'b11, 2'b11, 8'hA1, 8'hB1); smp; cyc;
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    smp; check_wr("t3d", 1'b1, 32'h000000B1, 32'h1, 32'h1); cyc;
    smp; check_wr("t3e", 1'b1, 32'h000000A1, 32'h0, 32'h1); cyc;

    // FIFO full holds the pending word.
    full = 1'b1;
    drive(2'b01, 2'b01, 8'h5A, 8'h00); smp; cyc;
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    for (int k = 0; k < 5; k++) begin
      smp;
      check_eq("t4.req", 32'(wr_req), 32'h0);
      check_eq("t4.ready0", 32'(in_ready[0]), 32'h0);
      cyc;
    end
    full = 1'b0;
    smp; check_wr("t4", 1'b1, 32'h0000005A, 32'h0, 32'h1); cyc;

    // Enable low: packing continues, writes wait; ptr=1 so requester 1 goes first.
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive((k == 0) ? 2'b11 : 2'b01, (k == 0) ? 2'b10 : 2'b00, 8'(8'hC1 + k), 8'hD1);
      smp;
      check_eq("t5.hold", 32'(wr_req), 32'h0);
      cyc;
    end
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    smp;
    check_eq("t5.ready", 32'(in_ready), 32'h0);
    check_eq("t5.hold2", 32'(wr_req), 32'h0);
    cyc;
    en = 1'b1;
    smp; check_wr("t5a", 1'b1, 32'h000000D1, 32'h1, 32'h1); cyc;
    smp; check_wr("t5b", 1'b1, 32'hC4C3C2C1, 32'h0, 32'h4); cyc;
    smp; check_eq("t5.idle", 32'(wr_req), 32'h0); cyc;

    // Reset mid-word discards the partial beats.
    drive(2'b01, 2'b00, 8'h77, 8'h00); smp; cyc;
    drive(2'b01, 2'b00, 8'h88, 8'h00); smp; cyc;
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    rstn = 1'b0;
    smp;
    check_eq("t6.rst_ready", 32'(in_ready), 32'h0);
    cyc;
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, 2'b00, 8'(k + 1), 8'h00);
      smp;
      check_eq("t6.idle", 32'(wr_req), 32'h0);
      cyc;
    end
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    smp; check_wr("t6", 1'b1, 32'h04030201, 32'h0, 32'h4); cyc;
    smp; check_eq("t6.after", 32'(wr_req), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
